// File: rtl/sort_driver_pkg.sv
// sort_driver_pkg: shared FSM states and constants for the sort_driver initiator
package sort_driver_pkg;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int RD_LAT = 3;
  localparam int LW = $clog2(RD_LAT);
  localparam logic [15:0] CYC_MAX = 16'hFFFF;
  typedef enum logic [2:0] {LOAD, GAP, START, WAIT_FALL, WAIT_RISE, RD_WAIT, EMIT} state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CYC_MAX) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/sort_driver.sv
// sort_driver: loads 8 bytes into the selection sorter, runs it, streams the sorted bytes out
module sort_driver
  import sort_driver_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             sort_wr,
  output logic [AW-1:0]    sort_addr,
  output logic [WIDTH-1:0] sort_datain,
  output logic             sort_start,
  input  logic [WIDTH-1:0] sort_dataout,
  input  logic             sort_ready,
  output logic             busy,
  output logic [15:0]      sort_cycles
);
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [15:0] cyc_q, cyc_d;
  logic [WIDTH-1:0] din_q, din_d, out_data_q, out_data_d;
  logic in_ready_q, wr_q, start_q, busy_q, out_valid_q, out_valid_d, beat;
  // in_ready_q is only ever set when heading into LOAD, so a beat implies LOAD
  assign beat = in_valid && in_ready_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    lat_d = lat_q;
    addr_d = addr_q;
    din_d = din_q;
    cyc_d = cyc_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    case (state_q)
      LOAD: if (beat) begin
        addr_d = cnt_q;
        din_d = in_data;
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) state_d = GAP;
      end
      GAP: state_d = START;
      START: begin
        cyc_d = '0;
        state_d = WAIT_FALL;
      end
      WAIT_FALL: begin
        cyc_d = sat_inc(cyc_q);
        if (!sort_ready) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        cyc_d = sat_inc(cyc_q);
        if (sort_ready) begin
          addr_d = cnt_q;
          lat_d = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: if (lat_q == LW'(RD_LAT - 1)) begin
        out_data_d = sort_dataout;
        out_valid_d = 1'b1;
        state_d = EMIT;
      end else lat_d = lat_q + LW'(1);
      EMIT: if (out_ready) begin
        out_valid_d = 1'b0;
        cnt_d = cnt_q + AW'(1);
        state_d = (cnt_q == AW'(DEPTH - 1)) ? LOAD : RD_WAIT;
        addr_d = (cnt_q == AW'(DEPTH - 1)) ? addr_q : cnt_q + AW'(1);
        lat_d = '0;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q <= '0;
      lat_q <= '0;
      addr_q <= '0;
      din_q <= '0;
      cyc_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      in_ready_q <= 1'b0;
      wr_q <= 1'b0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lat_q <= lat_d;
      addr_q <= addr_d;
      din_q <= din_d;
      cyc_q <= cyc_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      in_ready_q <= (state_d == LOAD) && sort_ready;
      wr_q <= beat;
      start_q <= (state_q == START);
      busy_q <= !((state_d == LOAD) && (cnt_d == '0));
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign sort_wr = wr_q;
  assign sort_addr = addr_q;
  assign sort_datain = din_q;
  assign sort_start = start_q;
  assign busy = busy_q;
  assign sort_cycles = cyc_q;
endmodule
